// File: rtl/hash_loop_sched_pkg.sv
// Shared definitions for the nonce-search scheduler and the loop watchdog.
package hash_sched_defs;

  localparam int unsigned LOOP_W      = 16;
  localparam int unsigned NONCE_W_DEF = 32;
  localparam int unsigned HASH_W_DEF  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CHECK = 3'd2,
    FOUND = 3'd3,
    FAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/hash_loop_sched.sv
// Nonce-search scheduler: walks nonces through the hash core until a result
// meets the target or the loop watchdog reports its limit.
module hash_loop_sched
  import hash_sched_defs::*;
#(
  parameter int unsigned NONCE_W = NONCE_W_DEF,
  parameter int unsigned HASH_W  = HASH_W_DEF,
  parameter int unsigned LOOP_W  = hash_sched_defs::LOOP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NONCE_W-1:0] seed,
  input  logic [HASH_W-1:0]  target,
  output logic               hash_req,
  output logic [NONCE_W-1:0] hash_nonce,
  input  logic               hash_ack,
  input  logic [HASH_W-1:0]  hash_value,
  output logic [LOOP_W-1:0]  current_loop,
  output logic               stop,
  input  logic               fail,
  input  logic [LOOP_W-1:0]  current_loop_actualize,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [LOOP_W-1:0]  loops_done
);

  state_t             state;
  state_t             state_nx;
  logic [NONCE_W-1:0] nonce;
  logic [HASH_W-1:0]  target_r;
  logic [HASH_W-1:0]  hash_r;
  logic               fail_seen;
  logic               accept;
  logic               hit;
  logic               give_up;

  // Next state, handshake outputs and per-cycle decisions.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hit      = 1'b0;
    give_up  = 1'b0;
    hash_req = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE, FOUND, FAIL: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        hash_req = 1'b1;
        busy     = 1'b1;
        if (hash_ack) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        // A hit outranks a watchdog failure observed in the same iteration.
        if (hash_r <= target_r) begin
          hit      = 1'b1;
          state_nx = FOUND;
        end else if (fail_seen || fail) begin
          give_up  = 1'b1;
          state_nx = FAIL;
        end else begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Search datapath: nonce/loop counters, captured hash and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nonce        <= '0;
      target_r     <= '0;
      hash_r       <= '0;
      fail_seen    <= 1'b0;
      current_loop <= '0;
      stop         <= 1'b0;
      found        <= 1'b0;
      found_nonce  <= '0;
      loops_done   <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        nonce        <= seed;
        target_r     <= target;
        current_loop <= '0;
        stop         <= 1'b0;
        found        <= 1'b0;
        fail_seen    <= 1'b0;
      end
      if (state == REQ) begin
        if (fail)     fail_seen <= 1'b1;
        if (hash_ack) hash_r    <= hash_value;
      end
      if (state == CHECK) begin
        if (hit) begin
          found_nonce <= nonce;
          found       <= 1'b1;
          stop        <= 1'b1;
          done        <= 1'b1;
          loops_done  <= current_loop_actualize;
        end else begin
          nonce <= nonce + 1'b1;
          if (current_loop != '1) current_loop <= current_loop + 1'b1;
          if (give_up) begin
            found      <= 1'b0;
            stop       <= 1'b1;
            done       <= 1'b1;
            loops_done <= current_loop_actualize;
          end
        end
      end
    end
  end

  assign hash_nonce = nonce;

endmodule

// File: tb/tb_hash_loop_sched.sv
module tb_hash_loop_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [31:0] target = '0;
  logic        hash_req;
  logic [31:0] hash_nonce;
  logic        hash_ack = 1'b0;
  logic [31:0] hash_value = '0;
  logic [15:0] current_loop;
  logic        stop;
  logic        fail = 1'b0;
  logic [15:0] cla = '0;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;
  logic [15:0] loops_done;

  hash_loop_sched #(.NONCE_W(32), .HASH_W(32), .LOOP_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .target(target),
    .hash_req(hash_req), .hash_nonce(hash_nonce), .hash_ack(hash_ack),
    .hash_value(hash_value), .current_loop(current_loop), .stop(stop),
    .fail(fail), .current_loop_actualize(cla), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce), .loops_done(loops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic [31:0] n;
    logic [15:0] ld;
    logic [15:0] cl;
  } res_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] salt = '0;
  logic [31:0] hq[$];
  logic [31:0] exp_nonce[$];
  res_t        exp_res[$];
  int          done_cnt = 0;
  int          dmin = 0;
  int          dmax = 0;
  int          wd_limit = 1000000;
  int          wcnt = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hfun(input logic [31:0] n);
    logic [31:0] x;
    x = n ^ salt;
    x = x ^ (x >> 16);
    x = x * 32'h045d_9f3b;
    x = x ^ (x >> 16);
    return x;
  endfunction

  // Hash core and loop watchdog models, driven away from the active edge.
  always @(negedge clk) begin
    hash_ack = 1'b0;
    if (reset && hash_req) begin
      if (wcnt < 0) wcnt = $urandom_range(dmax, dmin);
      if (wcnt == 0) begin
        hash_ack   = 1'b1;
        hash_value = (hq.size() > 0) ? hq.pop_front() : hfun(hash_nonce);
        wcnt       = -1;
      end else begin
        wcnt--;
      end
    end else begin
      wcnt = -1;
      if ($urandom_range(3, 0) == 0) begin
        hash_ack   = 1'b1;
        hash_value = '0;
      end
    end
    cla  = current_loop;
    fail = (int'(cla) >= wd_limit);
  end

  // Monitor: pops expectations whenever the DUT completes a hash or a search.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_nonce = '0;
  res_t        mr;
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      if (prev_req && !prev_ack) begin
        chk("req_held", hash_req, 1);
        chk("nonce_stable", hash_nonce, prev_nonce);
      end
      if (prev_req && prev_ack) chk("req_drop_after_ack", hash_req, 0);
      if (hash_req) chk("busy_in_req", busy, 1);
      if (hash_req && hash_ack) begin
        if (exp_nonce.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got nonce %0h expected none", hash_nonce);
        end else begin
          chk("hash_nonce", hash_nonce, exp_nonce.pop_front());
        end
      end
      if (done) begin
        chk("done_pulse", prev_done, 0);
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no search end");
        end else begin
          mr = exp_res.pop_front();
          chk("found", found, mr.f);
          if (mr.f) chk("found_nonce", found_nonce, mr.n);
          chk("loops_done", loops_done, mr.ld);
          chk("current_loop", current_loop, mr.cl);
          chk("stop_at_end", stop, 1);
          chk("busy_at_end", busy, 0);
          chk("req_at_end", hash_req, 0);
        end
        done_cnt++;
      end
      prev_req   = hash_req;
      prev_ack   = hash_ack;
      prev_done  = done;
      prev_nonce = hash_nonce;
    end else begin
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic run_search(input logic [31:0] s, input logic [31:0] t, input int lim,
                            input int dlo, input int dhi, input bit mid_start);
    logic [31:0] tab[$];
    logic [31:0] n;
    logic [31:0] h;
    res_t        r;
    int          d0;
    int          b;
    int          budget;
    tab = hq;
    for (int k = 0; ; k++) begin
      n = s + k;
      h = (k < tab.size()) ? tab[k] : hfun(n);
      exp_nonce.push_back(n);
      if (h <= t) begin
        r.f = 1'b1; r.n = n; r.ld = 16'(k); r.cl = 16'(k);
        break;
      end
      if (k >= lim) begin
        r.f = 1'b0; r.n = '0; r.ld = 16'(k); r.cl = 16'(k + 1);
        break;
      end
    end
    exp_res.push_back(r);
    dmin = dlo; dmax = dhi; wd_limit = lim;
    d0 = done_cnt;
    @(negedge clk);
    seed = s; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed = $urandom; target = $urandom;
    #1;
    chk("start_clears_stop", stop, 0);
    chk("start_clears_found", found, 0);
    chk("start_clears_loop", current_loop, 0);
    chk("busy_after_start", busy, 1);
    budget = (lim + 2) * (dhi + 2) + 50;
    b = 0;
    while (done_cnt == d0 && b < budget) begin
      @(negedge clk);
      b++;
      if (mid_start && b == 2) begin
        start = 1'b1; seed = s ^ 32'h5a5a_0f0f; target = '1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL search_timeout: got no done after %0d cycles expected done", b);
    end
    chk("nonces_consumed", exp_nonce.size(), 0);
    repeat ($urandom_range(3, 1)) @(negedge clk);
    #1;
    chk("hold_stop", stop, 1);
    chk("hold_found", found, r.f);
    if (r.f) chk("hold_found_nonce", found_nonce, r.n);
    chk("hold_loops_done", loops_done, r.ld);
    chk("hold_done_low", done, 0);
    chk("hold_busy_low", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hash_req"}, hash_req, 0);
    chk({tag, "_hash_nonce"}, hash_nonce, 0);
    chk({tag, "_current_loop"}, current_loop, 0);
    chk({tag, "_stop"}, stop, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_found_nonce"}, found_nonce, 0);
    chk({tag, "_loops_done"}, loops_done, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    salt = $urandom;

    hq = '{32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0005};
    run_search(32'h0000_0100, 32'h0000_0010, 1000, 2, 2, 1'b0);

    hq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    run_search(32'hFFFF_FFFF, 32'h0000_0010, 1000, 0, 0, 1'b0);

    hq = '{32'h0000_0000};
    run_search(32'h0000_0abc, 32'h0000_0010, 0, 10, 10, 1'b0);

    hq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    run_search(32'h0000_1234, 32'h0000_0004, 1000, 5, 5, 1'b1);

    hq.delete();
    run_search($urandom, 32'h0000_0000, 5000, 0, 0, 1'b0);

    hq.delete();
    run_search($urandom, 32'h0000_0000, 3, 0, 2, 1'b0);

    for (int i = 0; i < 25; i++) begin
      hq.delete();
      run_search($urandom, $urandom >> $urandom_range(7, 0), $urandom_range(12, 0),
                 0, $urandom_range(3, 0), 1'b0);
    end

    hq.delete();
    dmin = 20; dmax = 20; wd_limit = 1000000;
    @(negedge clk);
    seed = 32'h0000_5000; target = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("req_before_reset", hash_req, 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_nonce.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("idle_after_reset_req", hash_req, 0);
      chk("idle_after_reset_busy", busy, 0);
    end

    hq.delete();
    run_search($urandom, $urandom >> 4, 6, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish expected finish before 800000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hash_loop_sched.md
Name: hash_loop_sched

Overview:
Nonce-search scheduler for the hash datapath. On start it issues successive nonces to the hash core over a req/ack handshake and compares each hash result against a target. It drives the loop watchdog's current_loop/stop inputs and honours its fail output. It reports either the winning nonce or a loop-limit failure.

Parameters:
NONCE_W, 32, width of nonce and seed
HASH_W, 32, width of hash result and target
LOOP_W, 16, loop counter width; fixed to match the watchdog interface

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a search; ignored while busy
seed  in  NONCE_W  first nonce; sampled on accepted start
target  in  HASH_W  success threshold; sampled on accepted start
hash_req  out  1  request to hash core
hash_nonce  out  NONCE_W  nonce presented with hash_req
hash_ack  in  1  hash core completion; hash_value valid in the same cycle
hash_value  in  HASH_W  hash result
current_loop  out  LOOP_W  iterations completed in this search, to watchdog
stop  out  1  search finished, to watchdog
fail  in  1  watchdog loop-limit exceeded
current_loop_actualize  in  LOOP_W  watchdog's registered loop count
busy  out  1  search in progress
done  out  1  one-cycle pulse when a search ends
found  out  1  last search succeeded; held until next accepted start
found_nonce  out  NONCE_W  winning nonce; valid while found=1
loops_done  out  LOOP_W  copy of current_loop_actualize latched when done pulses

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs are 0, including hash_nonce, current_loop, found_nonce and loops_done.
- States: IDLE, REQ, CHECK, FOUND, FAIL. busy=1 in REQ and CHECK only.
- IDLE/FOUND/FAIL + start=1: latch seed into nonce and target into target_r. Clear current_loop, stop, found. Go to REQ next cycle.
- REQ: hash_req=1, hash_nonce=nonce, both held stable until hash_ack.
  - On hash_ack: register hash_value and go to CHECK.
  - hash_ack outside REQ is ignored.
- CHECK (1 cycle, hash_req=0):
  - If hash_r <= target_r (unsigned): found_nonce=nonce, found=1, stop=1, go to FOUND.
  - Otherwise nonce+1 (wraps mod 2^NONCE_W) and current_loop+1 (saturates at 2^LOOP_W-1). Then go to FAIL if fail_seen, else REQ.
- fail handling:
  - fail=1 in REQ sets fail_seen. The outstanding handshake always completes: hash_req stays high until hash_ack.
  - fail=1 in CHECK counts as fail_seen for that cycle.
  - A hit in CHECK takes precedence over fail.
- FAIL entry: stop=1, found=0.
- done pulses for exactly one cycle on entry to FOUND or FAIL. On that same edge, loops_done=current_loop_actualize.
- FOUND/FAIL: hold stop, found, found_nonce and loops_done until an accepted start or reset.
- start while busy: ignored; no queueing.
- fail while in IDLE/FOUND/FAIL: ignored; fail_seen is cleared on every accepted start.
- Minimum iteration: REQ (≥1 cycle) + CHECK (1 cycle). With hash_ack returned in the first REQ cycle, one hash completes every 2 cycles.
- Reset during REQ: hash_req drops asynchronously. The hash core must tolerate an abandoned request.

Decomposition:
- Shared include/package hash_sched_defs holds:
  - state encodings: IDLE=3'd0, REQ=3'd1, CHECK=3'd2, FOUND=3'd3, FAIL=3'd4
  - LOOP_W=16, shared with the loop watchdog
  - default NONCE_W/HASH_W
- Single module with no sub-modules. The nonce/loop counters and compare are too small to split.

Test Plan:
- seed=0x100, target=0x10, hash core returns 0xFFFF_FFFF, 0x20, 0x05 with ack 2 cycles after req → found=1, found_nonce=0x102, current_loop=2, stop=1, done one pulse, busy=0.
- Target never met, watchdog limit 5000 → fail seen at current_loop=5000, FAIL entered at next CHECK, stop=1, found=0, loops_done=current_loop_actualize, hash_req low.
- fail asserted mid-REQ with ack delayed 10 cycles → hash_req held until ack; CHECK hit (hash 0 ≤ target) → FOUND wins over fail.
- seed=0xFFFF_FFFF, two misses → hash_nonce sequence FFFF_FFFF, 0000_0000, 0000_0001.
- start pulsed during REQ → ignored, nonce sequence unchanged. start in FOUND → stop, found and current_loop clear, new search runs from the new seed.
- reset low in REQ → all outputs 0 immediately; after release, idle until start.
